vi_sync_level_filt: RTL and testbench
=====================================

Name: vi_sync_level_filt

Overview:
- Multi-channel level synchronizer with a configurable number of synchronizer stages and a per-channel stability (debounce) filter.
- Also generates per-channel rise/fall pulses and sticky glitch flags.
- Sits at clock-domain and pad boundaries where slow status levels (link up, LOS, SFP present, config straps) enter the clk domain.
- Replaces bare 1/2-flop level syncs where glitch rejection and edge events are needed.

Parameters:
SIZE, 4, number of independent 1-bit channels (1..64)
SYNC_STAGES, 2, synchronizer flop count per channel (2..4)
FILT_CYCLES, 4, consecutive cycles a new synced value must persist before out_level updates (1..1024)
RST_VAL, {SIZE{1'b0}}, per-channel reset value of sync chain and out_level

Ports:
clk  input  1  destination clock
rst  input  1  asynchronous, active-high reset
in_level  input  SIZE  asynchronous level inputs
filt_en  input  1  1 = apply FILT_CYCLES filter; 0 = behave as FILT_CYCLES=1 (must be quasi-static)
glitch_clr  input  1  synchronous clear of glitch_seen (single-cycle pulse or level)
out_level  output  SIZE  filtered, synchronized level
rise_pulse  output  SIZE  1-cycle pulse when out_level[i] goes 0->1
fall_pulse  output  SIZE  1-cycle pulse when out_level[i] goes 1->0
glitch_seen  output  SIZE  sticky: channel rejected a transition shorter than the filter

Behaviour:
- Single clock; rst is asynchronous and active-high. Every flop is reset by rst.
- Reset values:
  - sync chain = RST_VAL; out_level = RST_VAL.
  - rise_pulse = 0; fall_pulse = 0; glitch_seen = 0.
  - Per-channel counters = 0.
  - No pulses are generated on reset deassertion.
- Sync stage: SYNC_STAGES flops per channel, no logic between them; sync_q is the last stage.
- Filter, per channel i, with N = filt_en ? FILT_CYCLES : 1 and counter width $clog2(FILT_CYCLES+1). At each clk edge:
  - sync_q == out_level: cnt <= 0. If cnt was nonzero, glitch_seen[i] <= 1.
  - sync_q != out_level and cnt == N-1: out_level <= sync_q; cnt <= 0. Pulse the matching rise_pulse/fall_pulse at the same edge.
  - sync_q != out_level and cnt < N-1: cnt <= cnt+1.
- Latency: in_level changes, then is stable and first sampled at edge E1. out_level updates at edge E(SYNC_STAGES+N). Default is 6 clk edges; with filt_en=0 it is 3.
- Pulse rules:
  - rise_pulse and fall_pulse are registered.
  - Each is high exactly one cycle, coincident with the first cycle of the new out_level.
  - They are never both high on one channel.
  - Back-to-back opposite edges are separated by at least N cycles.
- Glitch flag:
  - glitch_seen[i] is set on any rejected excursion of 1..N-1 cycles.
  - It can never be set while filt_en=0, since N=1.
  - If glitch_clr coincides with a set event, set wins.
- filt_en change mid-count: the new N applies on the next edge. If cnt >= new N-1, the update occurs on that next edge.
- Channels are fully independent; no gray-code requirement on the bus. Multi-bit coherency is not guaranteed.
- Simulation-only assertions:
  - rise_pulse & fall_pulse == 0.
  - A pulse implies out_level != $past(out_level).
  - Parameters are checked for legal range at elaboration.

Test Plan:
- Reset (defaults): hold rst, in_level=4'hF; release rst -> out_level stays 0 for 5 cycles after release, rises on the 6th edge. rise_pulse=4'hF for exactly one cycle; no pulse at release.
- Glitch reject: filt_en=1, in_level[0] high for 3 cycles then low -> out_level[0] stays 0, no rise_pulse. glitch_seen[0]=1 until a glitch_clr pulse, then 0.
- Exact threshold: in_level[1] high for exactly 4 cycles -> out_level[1] rises 6 edges after first sample. fall_pulse occurs 4 cycles later on return low.
- Bypass: filt_en=0, toggle in_level[2] every 2 cycles -> out_level[2] follows with 3-cycle latency. Every edge produces a pulse; glitch_seen[2] stays 0.
- Async reset mid-count: assert rst while cnt=2 on channel 3 -> out_level, counters and pulses clear immediately, without waiting for a clk edge. Filtering restarts after release.
- Clear vs set collision: glitch_clr asserted on the same edge as a rejected excursion -> glitch_seen remains 1.

Source files
------------

// File: rtl/vi_sync_level_filt.sv
// Multi-channel level synchronizer with per-channel stability filter,
// registered rise/fall pulses and sticky glitch flags.
module vi_sync_level_filt #(
    parameter int unsigned      SIZE        = 4,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILT_CYCLES = 4,
    parameter logic [SIZE-1:0]  RST_VAL     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] in_level_i,
    input  logic            filt_en_i,
    input  logic            glitch_clr_i,
    output logic [SIZE-1:0] out_level_o,
    output logic [SIZE-1:0] rise_pulse_o,
    output logic [SIZE-1:0] fall_pulse_o,
    output logic [SIZE-1:0] glitch_seen_o
);

    localparam int unsigned CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES - 1);

    if (SIZE < 1 || SIZE > 64) begin : g_bad_size
        $error("vi_sync_level_filt: SIZE must be 1..64");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("vi_sync_level_filt: SYNC_STAGES must be 2..4");
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > 1024) begin : g_bad_filt
        $error("vi_sync_level_filt: FILT_CYCLES must be 1..1024");
    end

    logic [SIZE-1:0] sync_chain_q [SYNC_STAGES];
    logic [SIZE-1:0] sync_q;
    logic [CW-1:0]   cnt_q [SIZE];
    logic [CW-1:0]   cnt_d [SIZE];
    logic [SIZE-1:0] out_level_q, out_level_d;
    logic [SIZE-1:0] rise_q, rise_d;
    logic [SIZE-1:0] fall_q, fall_d;
    logic [SIZE-1:0] glitch_q, glitch_d;
    logic [CW-1:0]   last_cnt;

    assign sync_q   = sync_chain_q[SYNC_STAGES-1];
    // Using >= lets a shortened window (filt_en dropped mid-count) fire on the next edge.
    assign last_cnt = filt_en_i ? FILT_LAST : '0;

    // Per-channel filter: count persistence of a differing synced value.
    always_comb begin
        out_level_d = out_level_q;
        rise_d      = '0;
        fall_d      = '0;
        glitch_d    = glitch_q & ~{SIZE{glitch_clr_i}};
        cnt_d       = cnt_q;
        for (int i = 0; i < int'(SIZE); i++) begin
            if (sync_q[i] == out_level_q[i]) begin
                cnt_d[i] = '0;
                if (cnt_q[i] != '0) begin
                    glitch_d[i] = 1'b1;
                end
            end else if (cnt_q[i] >= last_cnt) begin
                out_level_d[i] = sync_q[i];
                cnt_d[i]       = '0;
                rise_d[i]      = sync_q[i];
                fall_d[i]      = ~sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_chain_q[s] <= RST_VAL;
            end
            for (int i = 0; i < int'(SIZE); i++) begin
                cnt_q[i] <= '0;
            end
            out_level_q <= RST_VAL;
            rise_q      <= '0;
            fall_q      <= '0;
            glitch_q    <= '0;
        end else begin
            sync_chain_q[0] <= in_level_i;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_chain_q[s] <= sync_chain_q[s-1];
            end
            cnt_q       <= cnt_d;
            out_level_q <= out_level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            glitch_q    <= glitch_d;
        end
    end

    assign out_level_o   = out_level_q;
    assign rise_pulse_o  = rise_q;
    assign fall_pulse_o  = fall_q;
    assign glitch_seen_o = glitch_q;

    a_no_dual_pulse : assert property (@(posedge clk) disable iff (rst)
        (rise_q & fall_q) == '0);
    a_pulse_means_change : assert property (@(posedge clk) disable iff (rst)
        (|(rise_q | fall_q)) |-> (out_level_q != $past(out_level_q)));

endmodule

// File: tb/tb_vi_sync_level_filt.sv
// Table-driven bench for vi_sync_level_filt with a per-cycle expectation queue.
module tb_vi_sync_level_filt;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_level = '0;
    logic         filt_en = 1'b1;
    logic         glitch_clr = 1'b0;
    logic [W-1:0] out_level, rise_pulse, fall_pulse, glitch_seen;

    vi_sync_level_filt #(
        .SIZE(W), .SYNC_STAGES(2), .FILT_CYCLES(4), .RST_VAL('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_level_i    (in_level),
        .filt_en_i     (filt_en),
        .glitch_clr_i  (glitch_clr),
        .out_level_o   (out_level),
        .rise_pulse_o  (rise_pulse),
        .fall_pulse_o  (fall_pulse),
        .glitch_seen_o (glitch_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] in_l;
        logic         fe;
        logic         clr;
        logic [W-1:0] out_l;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] gl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic [W-1:0] in_l, input logic fe, input logic clr,
                       input logic [W-1:0] o, input logic [W-1:0] r,
                       input logic [W-1:0] f, input logic [W-1:0] g);
        vec_t v;
        v.in_l = in_l; v.fe = fe; v.clr = clr;
        v.out_l = o; v.rise = r; v.fall = f; v.gl = g;
        tbl.push_back(v);
    endtask

    task automatic check_now(input string name, input logic [W-1:0] o,
                             input logic [W-1:0] r, input logic [W-1:0] f,
                             input logic [W-1:0] g);
        n_vec++;
        if (out_level !== o || rise_pulse !== r || fall_pulse !== f || glitch_seen !== g) begin
            n_err++;
            $display("FAIL %s: got out=%h rise=%h fall=%h glitch=%h, need out=%h rise=%h fall=%h glitch=%h",
                     name, out_level, rise_pulse, fall_pulse, glitch_seen, o, r, f, g);
        end
    endtask

    // Called at a negedge: drive each row, expect its outputs just after the next posedge.
    task automatic run_table(input string name);
        vec_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            in_level   = tbl[k].in_l;
            filt_en    = tbl[k].fe;
            glitch_clr = tbl[k].clr;
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_now($sformatf("%s[%0d]", name, k + 1), e.out_l, e.rise, e.fall, e.gl);
            @(negedge clk);
        end
        tbl.delete();
        glitch_clr = 1'b0;
    endtask

    // Ends at a negedge with rst just released.
    task automatic do_reset(input logic [W-1:0] in_l, input logic fe);
        @(negedge clk);
        rst = 1'b1; in_level = in_l; filt_en = fe; glitch_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_now("reset_hold", '0, '0, '0, '0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with all inputs high: rise lands on the 6th edge after release.
        do_reset(4'hF, 1'b1);
        for (int k = 1; k <= 5; k++) add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 0, 4'hF, 4'hF, 4'h0, 4'h0);
        add(4'hF, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        run_table("reset_rise");

        // Three-cycle excursion on ch0 is rejected and flagged, then cleared.
        do_reset(4'h0, 1'b1);
        for (int k = 1; k <= 3; k++) add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_table("glitch_reject");

        // Exactly-four-cycle pulse on ch1 passes; fall follows four cycles later.
        do_reset(4'h0, 1'b1);
        for (int k = 1; k <= 4; k++) add(4'h2, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h2, 4'h2, 4'h0, 4'h0);
        for (int k = 7; k <= 9; k++) add(4'h0, 1, 0, 4'h2, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h2, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_table("exact_thresh");

        // Bypass: ch2 toggles every 2 cycles, output follows with 3-edge latency.
        do_reset(4'h0, 1'b0);
        add(4'h4, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h4, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 0, 0, 4'h4, 4'h4, 4'h0, 4'h0);
        add(4'h0, 0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'h4, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
        add(4'h4, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 0, 0, 4'h4, 4'h4, 4'h0, 4'h0);
        add(4'h0, 0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'h0, 0, 0, 4'h0, 4'h0, 4'h4, 4'h0);
        add(4'h0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        run_table("bypass");

        // Bring all outputs high, then start a ch3 fall and reset mid-count.
        do_reset(4'h0, 1'b1);
        for (int k = 1; k <= 5; k++) add(4'hF, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 0, 4'hF, 4'hF, 4'h0, 4'h0);
        for (int k = 7; k <= 10; k++) add(4'h7, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        run_table("pre_async");
        rst = 1'b1;
        #1;
        check_now("async_rst", '0, '0, '0, '0);
        do_reset(4'h7, 1'b1);
        for (int k = 1; k <= 5; k++) add(4'h7, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h7, 1, 0, 4'h7, 4'h7, 4'h0, 4'h0);
        add(4'h7, 1, 0, 4'h7, 4'h0, 4'h0, 4'h0);
        run_table("post_async");

        // glitch_clr on the same edge as a set keeps the flag; alone it clears.
        do_reset(4'h0, 1'b1);
        add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h1);
        add(4'h0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h1);
        add(4'h0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        run_table("clr_vs_set");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
